ee201_clkdiv_multi: RTL and testbench

- Multi-channel, runtime-programmable clock divider. Successor to the fixed single-channel 60 Hz slow-clock generator.
- Each of NCH channels produces a 50%-duty divided square wave (ClkOut) and a one-Clk-cycle Tick at every edge of that wave.
- Divisors are reloaded at run time through a one-cycle load strobe and are applied glitch-free at the channel's next terminal count.
- Feeds display refresh, debounce, and game-timer logic from the 100 MHz board clock.

---
 rtl/ee201_clkdiv_multi.sv | 103 ++++++++++
 tb/tb_ee201_clkdiv_multi.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ee201_clkdiv_multi.sv
// ee201_clkdiv_multi: multi-channel, runtime-programmable clock divider.
// Each channel emits a 50%-duty square wave toggling every Nact cycles and a
// one-cycle tick on every toggle. A divisor written through Load is staged
// and applied at the channel's next terminal count (or immediately while the
// channel is stopped), so the output never shows a runt or glitch pulse.
module ee201_clkdiv_multi #(
  parameter int              NCH       = 4,
  parameter int              SELW      = 2,
  parameter int              WIDTH     = 21,
  parameter logic [WIDTH-1:0] DEFAULT_N = WIDTH'(833333)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [NCH-1:0]   En,
  input  logic             Load,
  input  logic [SELW-1:0]  LdSel,
  input  logic [WIDTH-1:0] LdN,
  output logic [NCH-1:0]   ClkOut,
  output logic [NCH-1:0]   Tick,
  output logic [NCH-1:0]   Pending
);

  // Per-channel state, packed so whole vectors can be registered at once.
  logic [NCH-1:0][WIDTH-1:0] cnt_q,   cnt_d;
  logic [NCH-1:0][WIDTH-1:0] nact_q,  nact_d;
  logic [NCH-1:0][WIDTH-1:0] nnext_q, nnext_d;
  logic [NCH-1:0]            pend_q,  pend_d;
  logic [NCH-1:0]            clk_q,   clk_d;
  logic [NCH-1:0]            tick_q,  tick_d;

  // Next-state logic: counting, terminal-count divisor transfer, and staging of loads.
  always_comb begin
    cnt_d   = cnt_q;
    nact_d  = nact_q;
    nnext_d = nnext_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = tick_q;
    for (int i = 0; i < NCH; i++) begin
      if (En[i] && (nact_q[i] != {WIDTH{1'b0}})) begin
        if (cnt_q[i] == (nact_q[i] - WIDTH'(1))) begin
          // Terminal count: toggle, tick, and the only safe point to swap divisors.
          cnt_d[i]  = {WIDTH{1'b0}};
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
          if (pend_q[i]) begin
            nact_d[i] = nnext_q[i];
            pend_d[i] = 1'b0;
          end else begin
            nact_d[i] = nact_q[i];
            pend_d[i] = pend_q[i];
          end
        end else begin
          cnt_d[i]  = cnt_q[i] + WIDTH'(1);
          tick_d[i] = 1'b0;
        end
      end else begin
        // Stopped: counter parked at zero, so a staged divisor can go in right away.
        cnt_d[i]  = {WIDTH{1'b0}};
        tick_d[i] = 1'b0;
        if (pend_q[i]) begin
          nact_d[i] = nnext_q[i];
          pend_d[i] = 1'b0;
        end else begin
          nact_d[i] = nact_q[i];
          pend_d[i] = pend_q[i];
        end
      end
      // A load overrides the staging register last, so a load coinciding with a
      // terminal transfer leaves the new value pending while the old one is applied.
      if (Load && (LdSel == SELW'(i))) begin
        nnext_d[i] = LdN;
        pend_d[i]  = 1'b1;
      end else begin
        nnext_d[i] = nnext_q[i];
      end
    end
  end

  // State registers with asynchronous active-low reset back to the default divisor.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= {NCH{ {WIDTH{1'b0}} }};
      nact_q  <= {NCH{DEFAULT_N}};
      nnext_q <= {NCH{DEFAULT_N}};
      pend_q  <= {NCH{1'b0}};
      clk_q   <= {NCH{1'b0}};
      tick_q  <= {NCH{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      nact_q  <= nact_d;
      nnext_q <= nnext_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign ClkOut  = clk_q;
  assign Tick    = tick_q;
  assign Pending = pend_q;

endmodule

// File: tb/tb_ee201_clkdiv_multi.sv
// Directed bench for ee201_clkdiv_multi with three channels, 8-bit counters
// and a reset divisor of 5. Edge numbers in comments count posedges after
// the first reset release.
module tb_ee201_clkdiv_multi;

  logic       Clk;
  logic       Reset;
  logic [2:0] En;
  logic       Load;
  logic [1:0] LdSel;
  logic [7:0] LdN;
  logic [2:0] ClkOut;
  logic [2:0] Tick;
  logic [2:0] Pending;

  int checks = 0;
  int errors = 0;

  ee201_clkdiv_multi #(
    .NCH(3), .SELW(2), .WIDTH(8), .DEFAULT_N(8'd5)
  ) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Load(Load), .LdSel(LdSel), .LdN(LdN),
    .ClkOut(ClkOut), .Tick(Tick), .Pending(Pending)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] ec, input logic [2:0] et,
                     input logic [2:0] ep);
    checks++;
    assert (ClkOut === ec) else begin
      errors++;
      $error("FAIL %s ClkOut got %b want %b", tag, ClkOut, ec);
    end
    checks++;
    assert (Tick === et) else begin
      errors++;
      $error("FAIL %s Tick got %b want %b", tag, Tick, et);
    end
    checks++;
    assert (Pending === ep) else begin
      errors++;
      $error("FAIL %s Pending got %b want %b", tag, Pending, ep);
    end
  endtask

  initial begin
    Reset = 1'b0; En = 3'b000; Load = 1'b0; LdSel = 2'd0; LdN = 8'd0;
    #12;
    chk("reset", 3'b000, 3'b000, 3'b000);
    Reset = 1'b1;
    En = 3'b001;

    // ch0 at N=5: tick on every 5th edge, ClkOut high 5 / low 5
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("p1_e%0d", k), {2'b00, ((k / 5) % 2) == 1},
          {2'b00, (k % 5) == 0}, 3'b000);
    end

    // Load 3 at Cnt=1; current half-period still finishes at 5
    step();                                        // 21, cnt=1
    chk("p2_e21", 3'b000, 3'b000, 3'b000);
    Load = 1'b1; LdSel = 2'd0; LdN = 8'd3;
    step();                                        // 22
    Load = 1'b0;
    chk("p2_pend", 3'b000, 3'b000, 3'b001);
    step(); step();                                // 24
    chk("p2_old_half", 3'b000, 3'b000, 3'b001);
    step();                                        // 25
    chk("p2_term5", 3'b001, 3'b001, 3'b000);
    step(); step();                                // 27
    chk("p2_mid", 3'b001, 3'b000, 3'b000);
    step();                                        // 28
    chk("p2_term3a", 3'b000, 3'b001, 3'b000);
    step(); step(); step();                        // 31
    chk("p2_term3b", 3'b001, 3'b001, 3'b000);

    // Stage 7, then load 2 exactly on the terminal edge
    Load = 1'b1; LdN = 8'd7;
    step();                                        // 32
    Load = 1'b0;
    step();                                        // 33
    chk("p3_pend7", 3'b001, 3'b000, 3'b001);
    Load = 1'b1; LdN = 8'd2;
    step();                                        // 34, terminal applies 7
    Load = 1'b0;
    chk("p3_coinc", 3'b000, 3'b001, 3'b001);
    repeat (6) step();                             // 40
    chk("p3_hold7", 3'b000, 3'b000, 3'b001);
    step();                                        // 41, terminal applies 2
    chk("p3_term7", 3'b001, 3'b001, 3'b000);
    step();                                        // 42
    chk("p3_mid2", 3'b001, 3'b000, 3'b000);
    step();                                        // 43
    chk("p3_term2", 3'b000, 3'b001, 3'b000);
    step(); step();                                // 45
    chk("p4_clkhi", 3'b001, 3'b001, 3'b000);

    // Stop mid-count with ClkOut high and load 4 while stopped
    step();                                        // 46, cnt=1
    En = 3'b000; Load = 1'b1; LdSel = 2'd0; LdN = 8'd4;
    step();                                        // 47
    Load = 1'b0;
    chk("p4_stop", 3'b001, 3'b000, 3'b001);
    step();                                        // 48
    chk("p4_apply", 3'b001, 3'b000, 3'b000);
    step(); step();                                // 50
    chk("p4_hold", 3'b001, 3'b000, 3'b000);
    En = 3'b001;
    step(); step(); step();                        // 53
    chk("p4_pre", 3'b001, 3'b000, 3'b000);
    step();                                        // 54
    chk("p4_first", 3'b000, 3'b001, 3'b000);

    // ch2 at N=1: toggles every cycle, tick stays high
    En = 3'b000; Load = 1'b1; LdSel = 2'd2; LdN = 8'd1;
    step();                                        // 55
    Load = 1'b0;
    chk("p5_ld1", 3'b000, 3'b000, 3'b100);
    step();                                        // 56
    chk("p5_apply1", 3'b000, 3'b000, 3'b000);
    En = 3'b100;
    step();                                        // 57
    chk("p5_n1a", 3'b100, 3'b100, 3'b000);
    step();                                        // 58
    chk("p5_n1b", 3'b000, 3'b100, 3'b000);
    step(); step();                                // 60
    chk("p5_n1c", 3'b000, 3'b100, 3'b000);

    // Load 0 freezes ch2 after its next terminal
    Load = 1'b1; LdSel = 2'd2; LdN = 8'd0;
    step();                                        // 61
    Load = 1'b0;
    chk("p5_ld0", 3'b100, 3'b100, 3'b100);
    step();                                        // 62
    chk("p5_lastterm", 3'b000, 3'b100, 3'b000);
    step();                                        // 63
    chk("p5_frozen", 3'b000, 3'b000, 3'b000);

    // Out-of-range channel select is ignored
    Load = 1'b1; LdSel = 2'd3; LdN = 8'd9;
    step();                                        // 64
    Load = 1'b0;
    chk("p5_badsel", 3'b000, 3'b000, 3'b000);
    step();                                        // 65
    chk("p5_badsel2", 3'b000, 3'b000, 3'b000);

    // All channels enabled: ch0 N=4, ch1 N=5, ch2 N=0
    En = 3'b111;
    repeat (4) step();                             // 69
    chk("p6_ch0", 3'b001, 3'b001, 3'b000);
    Load = 1'b1; LdSel = 2'd1; LdN = 8'd2;
    step();                                        // 70
    Load = 1'b0;
    chk("p6_pre", 3'b011, 3'b010, 3'b010);

    // Asynchronous reset between edges, then clean restart at N=5 everywhere
    #2 Reset = 1'b0;
    #1 chk("p6_async", 3'b000, 3'b000, 3'b000);
    #1 Reset = 1'b1;
    repeat (4) step();
    chk("p6_r4", 3'b000, 3'b000, 3'b000);
    step();
    chk("p6_r5", 3'b111, 3'b111, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
